// File: rtl/clic_target_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | clic_target_arbiter: shares one core interrupt port among N CLIC       |
// | target handshakes, with latched payload and kill-based preemption.     |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module clic_target_arbiter #(
  parameter int unsigned N_TARGET  = 2,
  parameter int unsigned SrcWidth  = 8,
  parameter int unsigned PrioWidth = 8,
  parameter int unsigned ModeWidth = 2,
  parameter int unsigned VsidWidth = 6,
  parameter int unsigned TgtWidth  = (N_TARGET > 1) ? $clog2(N_TARGET) : 1
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [N_TARGET-1:0]                 tgt_valid_i,
  output logic [N_TARGET-1:0]                 tgt_ready_o,
  input  logic [N_TARGET-1:0][SrcWidth-1:0]   tgt_id_i,
  input  logic [N_TARGET-1:0][PrioWidth-1:0]  tgt_max_i,
  input  logic [N_TARGET-1:0][ModeWidth-1:0]  tgt_mode_i,
  input  logic [N_TARGET-1:0][VsidWidth-1:0]  tgt_vsid_i,
  input  logic [N_TARGET-1:0]                 tgt_v_i,
  input  logic [N_TARGET-1:0]                 tgt_shv_i,
  input  logic [N_TARGET-1:0]                 tgt_kill_req_i,
  output logic [N_TARGET-1:0]                 tgt_kill_ack_o,
  output logic                                irq_valid_o,
  input  logic                                irq_ready_i,
  output logic [SrcWidth-1:0]                 irq_id_o,
  output logic [PrioWidth-1:0]                irq_level_o,
  output logic [ModeWidth-1:0]                irq_mode_o,
  output logic [VsidWidth-1:0]                irq_vsid_o,
  output logic                                irq_v_o,
  output logic                                irq_shv_o,
  output logic                                irq_kill_req_o,
  input  logic                                irq_kill_ack_i,
  output logic [TgtWidth-1:0]                 irq_src_o
);

  localparam int unsigned KeyWidth = 2 + PrioWidth;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OFFER = 2'd1,
    ST_KILL  = 2'd2
  } state_e;

  // Machine mode first, then non-virtualized supervisor, then VS, then the rest.
  function automatic logic [KeyWidth-1:0] make_key(
    input logic [ModeWidth-1:0] mode,
    input logic                 v,
    input logic [PrioWidth-1:0] level
  );
    logic [1:0] rank;
    if (mode == ModeWidth'(3))            rank = 2'd3;
    else if (mode == ModeWidth'(1) && !v) rank = 2'd2;
    else if (mode == ModeWidth'(1))       rank = 2'd1;
    else                                  rank = 2'd0;
    return {rank, level};
  endfunction

  state_e                state_q, state_d;
  logic [TgtWidth-1:0]   src_q, src_d;
  logic [SrcWidth-1:0]   id_q, id_d;
  logic [PrioWidth-1:0]  level_q, level_d;
  logic [ModeWidth-1:0]  mode_q, mode_d;
  logic [VsidWidth-1:0]  vsid_q, vsid_d;
  logic                  v_q, v_d;
  logic                  shv_q, shv_d;
  logic                  cause_tgt_q, cause_tgt_d;

  logic [KeyWidth-1:0]   key_w [N_TARGET];
  logic [KeyWidth-1:0]   lat_key_w;
  logic [KeyWidth-1:0]   win_key_w;
  logic [TgtWidth-1:0]   win_idx_w;
  logic                  win_any_w;
  logic                  preempt_w;
  logic                  src_kill_w;
  logic [N_TARGET-1:0]   ready_w;
  logic [N_TARGET-1:0]   ack_w;

  for (genvar gi = 0; gi < N_TARGET; gi++) begin : g_key
    assign key_w[gi] = make_key(tgt_mode_i[gi], tgt_v_i[gi], tgt_max_i[gi]);
  end

  assign lat_key_w  = make_key(mode_q, v_q, level_q);
  assign src_kill_w = tgt_kill_req_i[src_q];

  // Strict compare on ascending index keeps the lowest index on equal keys.
  always_comb begin
    win_any_w = 1'b0;
    win_idx_w = '0;
    win_key_w = '0;
    for (int i = 0; i < N_TARGET; i++) begin
      if (tgt_valid_i[i] && (!win_any_w || key_w[i] > win_key_w)) begin
        win_any_w = 1'b1;
        win_idx_w = TgtWidth'(i);
        win_key_w = key_w[i];
      end
    end
  end

  always_comb begin
    preempt_w = 1'b0;
    for (int i = 0; i < N_TARGET; i++) begin
      if (tgt_valid_i[i] && (TgtWidth'(i) != src_q) && (key_w[i] > lat_key_w)) begin
        preempt_w = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    id_d        = id_q;
    level_d     = level_q;
    mode_d      = mode_q;
    vsid_d      = vsid_q;
    v_d         = v_q;
    shv_d       = shv_q;
    cause_tgt_d = cause_tgt_q;
    ready_w     = '0;
    ack_w       = '0;

    case (state_q)
      ST_IDLE: begin
        if (win_any_w) begin
          state_d     = ST_OFFER;
          src_d       = win_idx_w;
          id_d        = tgt_id_i[win_idx_w];
          level_d     = tgt_max_i[win_idx_w];
          mode_d      = tgt_mode_i[win_idx_w];
          vsid_d      = tgt_vsid_i[win_idx_w];
          v_d         = tgt_v_i[win_idx_w];
          shv_d       = tgt_shv_i[win_idx_w];
          cause_tgt_d = 1'b0;
        end
      end
      ST_OFFER, ST_KILL: begin
        // A core accept takes priority over any kill still in flight.
        if (irq_ready_i) begin
          ready_w[src_q] = 1'b1;
          state_d        = ST_IDLE;
        end else if (!tgt_valid_i[src_q]) begin
          state_d = ST_IDLE;
        end else if (state_q == ST_OFFER) begin
          if (src_kill_w || preempt_w) begin
            state_d     = ST_KILL;
            cause_tgt_d = src_kill_w;
          end
        end else if (irq_kill_ack_i) begin
          if (cause_tgt_q || src_kill_w) begin
            ack_w[src_q] = 1'b1;
          end
          state_d = ST_IDLE;
        end else if (src_kill_w) begin
          cause_tgt_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      src_q       <= '0;
      id_q        <= '0;
      level_q     <= '0;
      mode_q      <= '0;
      vsid_q      <= '0;
      v_q         <= 1'b0;
      shv_q       <= 1'b0;
      cause_tgt_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      id_q        <= id_d;
      level_q     <= level_d;
      mode_q      <= mode_d;
      vsid_q      <= vsid_d;
      v_q         <= v_d;
      shv_q       <= shv_d;
      cause_tgt_q <= cause_tgt_d;
    end
  end

  // Pulses are suppressed while reset is applied so an abort never completes a handshake.
  assign tgt_ready_o    = rst_i ? '0 : ready_w;
  assign tgt_kill_ack_o = rst_i ? '0 : ack_w;

  assign irq_valid_o    = (state_q != ST_IDLE);
  assign irq_kill_req_o = (state_q == ST_KILL);
  assign irq_id_o       = id_q;
  assign irq_level_o    = level_q;
  assign irq_mode_o     = mode_q;
  assign irq_vsid_o     = vsid_q;
  assign irq_v_o        = v_q;
  assign irq_shv_o      = shv_q;
  assign irq_src_o      = src_q;

endmodule
`default_nettype wire

// File: tb/tb_clic_target_arbiter.sv
`default_nettype none
// Randomized bench: a transaction-level model predicts offers and pulses;
// a negedge monitor compares DUT outputs against a scoreboard queue.
module tb_clic_target_arbiter;

  localparam int N  = 2;
  localparam int SW = 8;
  localparam int PW = 8;
  localparam int MW = 2;
  localparam int VW = 6;
  localparam int TW = 1;
  localparam int N_CYCLES = 4000;

  logic                  clk;
  logic                  rst;
  logic [N-1:0]          tgt_valid;
  logic [N-1:0]          tgt_ready;
  logic [N-1:0][SW-1:0]  tgt_id;
  logic [N-1:0][PW-1:0]  tgt_max;
  logic [N-1:0][MW-1:0]  tgt_mode;
  logic [N-1:0][VW-1:0]  tgt_vsid;
  logic [N-1:0]          tgt_v;
  logic [N-1:0]          tgt_shv;
  logic [N-1:0]          tgt_kill_req;
  logic [N-1:0]          tgt_kill_ack;
  logic                  irq_valid;
  logic                  irq_ready;
  logic [SW-1:0]         irq_id;
  logic [PW-1:0]         irq_level;
  logic [MW-1:0]         irq_mode;
  logic [VW-1:0]         irq_vsid;
  logic                  irq_v;
  logic                  irq_shv;
  logic                  irq_kill_req;
  logic                  irq_kill_ack;
  logic [TW-1:0]         irq_src;

  clic_target_arbiter #(
    .N_TARGET(N), .SrcWidth(SW), .PrioWidth(PW), .ModeWidth(MW), .VsidWidth(VW)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .tgt_valid_i(tgt_valid), .tgt_ready_o(tgt_ready),
    .tgt_id_i(tgt_id), .tgt_max_i(tgt_max), .tgt_mode_i(tgt_mode),
    .tgt_vsid_i(tgt_vsid), .tgt_v_i(tgt_v), .tgt_shv_i(tgt_shv),
    .tgt_kill_req_i(tgt_kill_req), .tgt_kill_ack_o(tgt_kill_ack),
    .irq_valid_o(irq_valid), .irq_ready_i(irq_ready),
    .irq_id_o(irq_id), .irq_level_o(irq_level), .irq_mode_o(irq_mode),
    .irq_vsid_o(irq_vsid), .irq_v_o(irq_v), .irq_shv_o(irq_shv),
    .irq_kill_req_o(irq_kill_req), .irq_kill_ack_i(irq_kill_ack),
    .irq_src_o(irq_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    bit is_ack;
    int idx;
  } ev_t;

  ev_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  cyc     = 0;

  // Reference model state (value holding after the most recent clock edge).
  bit m_act, m_kill, m_ctgt, m_since;
  int m_src, m_id, m_lvl, m_mode, m_vsid, m_v, m_shv;
  // Snapshot of the model for the current cycle, read by the monitor.
  bit cur_valid, cur_kill, cur_since;
  int cur_src, cur_id, cur_lvl, cur_mode, cur_vsid, cur_v, cur_shv;

  // Behavioural targets.
  bit t_pend[N], t_kr[N], t_done[N];
  int t_id[N], t_lvl[N], t_mode[N], t_vsid[N], t_v[N], t_shv[N];

  function automatic int key_of(int mode, int v, int lvl);
    int rank;
    if (mode == 3)                rank = 3;
    else if (mode == 1 && v == 0) rank = 2;
    else if (mode == 1)           rank = 1;
    else                          rank = 0;
    return rank * 256 + lvl;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_act = 0; m_kill = 0; m_ctgt = 0; m_since = 1;
    m_src = 0; m_id = 0; m_lvl = 0; m_mode = 0; m_vsid = 0; m_v = 0; m_shv = 0;
  endtask

  task automatic model_step(input bit r, input bit rdy, input bit kack);
    int best, best_key, lkey;
    bit pre, kr_src;
    if (r) begin
      model_reset();
      return;
    end
    if (!m_act) begin
      best = -1; best_key = -1;
      for (int i = 0; i < N; i++)
        if (t_pend[i] && key_of(t_mode[i], t_v[i], t_lvl[i]) > best_key) begin
          best = i; best_key = key_of(t_mode[i], t_v[i], t_lvl[i]);
        end
      if (best >= 0) begin
        m_act = 1; m_kill = 0; m_ctgt = 0; m_since = 0; m_src = best;
        m_id = t_id[best]; m_lvl = t_lvl[best]; m_mode = t_mode[best];
        m_vsid = t_vsid[best]; m_v = t_v[best]; m_shv = t_shv[best];
      end
      return;
    end
    kr_src = t_kr[m_src];
    if (rdy) begin
      exp_q.push_back('{cyc: cyc, is_ack: 1'b0, idx: m_src});
      t_done[m_src] = 1;
      m_act = 0; m_kill = 0;
    end else if (!t_pend[m_src]) begin
      m_act = 0; m_kill = 0;
    end else if (!m_kill) begin
      lkey = key_of(m_mode, m_v, m_lvl);
      pre = 0;
      for (int j = 0; j < N; j++)
        if (j != m_src && t_pend[j] && key_of(t_mode[j], t_v[j], t_lvl[j]) > lkey) pre = 1;
      if (kr_src || pre) begin
        m_kill = 1; m_ctgt = kr_src;
      end
    end else if (kack) begin
      if (m_ctgt || kr_src) begin
        exp_q.push_back('{cyc: cyc, is_ack: 1'b1, idx: m_src});
        t_done[m_src] = 1;
      end
      m_act = 0; m_kill = 0;
    end else if (kr_src) begin
      m_ctgt = 1;
    end
  endtask

  // Monitor: levels against the model snapshot, pulses against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (cyc > 0) begin
        check("irq_valid", 32'(irq_valid), 32'(cur_valid));
        check("irq_kill_req", 32'(irq_kill_req), 32'(cur_kill));
        if (cur_valid || cur_since) begin
          check("irq_src", 32'(irq_src), cur_src);
          check("irq_id", 32'(irq_id), cur_id);
          check("irq_level", 32'(irq_level), cur_lvl);
          check("irq_mode", 32'(irq_mode), cur_mode);
          check("irq_vsid", 32'(irq_vsid), cur_vsid);
          check("irq_v", 32'(irq_v), cur_v);
          check("irq_shv", 32'(irq_shv), cur_shv);
        end
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
          n_tests++; n_fail++;
          $display("FAIL pulse_missed: got none expected %s idx %0d at cycle %0d",
                   exp_q[0].is_ack ? "kill_ack" : "ready", exp_q[0].idx, exp_q[0].cyc);
          void'(exp_q.pop_front());
        end
        if (tgt_ready != '0 || tgt_kill_ack != '0) begin
          n_tests++;
          if (!(exp_q.size() > 0 && exp_q[0].cyc == cyc)) begin
            n_fail++;
            $display("FAIL pulse_unexpected cycle %0d: got ready=%b ack=%b expected none",
                     cyc, tgt_ready, tgt_kill_ack);
          end else begin
            ev_t e;
            logic [N-1:0] want, got;
            e = exp_q.pop_front();
            want = '0;
            want[e.idx] = 1'b1;
            got = e.is_ack ? tgt_kill_ack : tgt_ready;
            if (got != want || (e.is_ack ? tgt_ready : tgt_kill_ack) != '0) begin
              n_fail++;
              $display("FAIL pulse_value cycle %0d: got ready=%b ack=%b expected %s=%b",
                       cyc, tgt_ready, tgt_kill_ack, e.is_ack ? "ack" : "ready", want);
            end
          end
        end else if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
          n_tests++; n_fail++;
          $display("FAIL pulse_missed cycle %0d: got none expected %s idx %0d",
                   cyc, exp_q[0].is_ack ? "kill_ack" : "ready", exp_q[0].idx);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // Stimulus: drive each cycle #1 after the edge, then advance the model.
  initial begin
    bit r, rdy, kack;
    rst = 1'b1; tgt_valid = '0; tgt_id = '0; tgt_max = '0; tgt_mode = '0;
    tgt_vsid = '0; tgt_v = '0; tgt_shv = '0; tgt_kill_req = '0;
    irq_ready = 1'b0; irq_kill_ack = 1'b0;
    for (int i = 0; i < N; i++) begin
      t_pend[i] = 0; t_kr[i] = 0; t_done[i] = 0;
      t_id[i] = 0; t_lvl[i] = 0; t_mode[i] = 0; t_vsid[i] = 0; t_v[i] = 0; t_shv[i] = 0;
    end
    model_reset();
    for (int c = 0; c < N_CYCLES; c++) begin
      @(posedge clk);
      #1;
      cyc++;
      cur_valid = m_act; cur_kill = m_kill; cur_since = m_since; cur_src = m_src;
      cur_id = m_id; cur_lvl = m_lvl; cur_mode = m_mode; cur_vsid = m_vsid;
      cur_v = m_v; cur_shv = m_shv;
      for (int i = 0; i < N; i++) begin
        int p;
        p = int'($urandom_range(0, 99));
        if (t_done[i]) begin
          t_pend[i] = 0; t_kr[i] = 0; t_done[i] = 0;
        end else if (t_pend[i]) begin
          if (p < 3) begin
            t_pend[i] = 0; t_kr[i] = 0;
          end else if (p < 8) begin
            t_kr[i] = 1;
          end else if (p < 14) begin
            t_id[i] = int'($urandom_range(0, 255));
          end
        end else if (p < 30) begin
          t_pend[i] = 1; t_kr[i] = 0;
          t_mode[i] = int'($urandom_range(0, 3));
          t_v[i]    = int'($urandom_range(0, 1));
          t_lvl[i]  = ($urandom_range(0, 3) == 0) ? 255 : int'($urandom_range(0, 7));
          t_id[i]   = int'($urandom_range(0, 255));
          t_vsid[i] = int'($urandom_range(0, 63));
          t_shv[i]  = int'($urandom_range(0, 1));
        end
      end
      r    = (cyc <= 3) || ($urandom_range(0, 299) == 0);
      rdy  = ($urandom_range(0, 3) == 0);
      kack = ($urandom_range(0, 2) == 0);
      rst = r; irq_ready = rdy; irq_kill_ack = kack;
      for (int i = 0; i < N; i++) begin
        tgt_valid[i]    = t_pend[i];
        tgt_kill_req[i] = t_kr[i];
        tgt_id[i]       = SW'(t_id[i]);
        tgt_max[i]      = PW'(t_lvl[i]);
        tgt_mode[i]     = MW'(t_mode[i]);
        tgt_vsid[i]     = VW'(t_vsid[i]);
        tgt_v[i]        = t_v[i][0];
        tgt_shv[i]      = t_shv[i][0];
      end
      model_step(r, rdy, kack);
    end
    @(negedge clk);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending events expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/clic_target_arbiter.md
Name: clic_target_arbiter

Overview:
- Shares a single core interrupt port between N_TARGET CLIC target handshake interfaces, e.g. an M/S-mode CLIC instance plus a VS-context instance.
- Selects the strongest pending request and latches its payload onto the core port.
- Forwards the valid/ready and kill handshakes to the selected target.
- Preempts a pending offer via kill when a stronger target appears.
- Sits between the clic_target instances and the hart.

Parameters:
- N_TARGET, 2, number of arbitrated target interfaces (>=2).
- SrcWidth, 8, interrupt id width.
- PrioWidth, 8, interrupt level width.
- ModeWidth, 2, privilege mode width.
- VsidWidth, 6, virtual supervisor id width.
- TgtWidth, $clog2(N_TARGET), derived; must not be overridden.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- tgt_valid_i  in  N_TARGET  per-target irq valid.
- tgt_ready_o  out  N_TARGET  per-target ready, one-cycle pulse.
- tgt_id_i  in  N_TARGET x SrcWidth  per-target irq id.
- tgt_max_i  in  N_TARGET x PrioWidth  per-target level.
- tgt_mode_i  in  N_TARGET x ModeWidth  per-target mode.
- tgt_vsid_i  in  N_TARGET x VsidWidth  per-target vsid.
- tgt_v_i  in  N_TARGET  per-target virtualized flag.
- tgt_shv_i  in  N_TARGET  per-target selective-hardware-vectoring flag.
- tgt_kill_req_i  in  N_TARGET  per-target kill request.
- tgt_kill_ack_o  out  N_TARGET  per-target kill ack, one-cycle pulse.
- irq_valid_o  out  1  core irq valid.
- irq_ready_i  in  1  core accept.
- irq_id_o / irq_level_o / irq_mode_o / irq_vsid_o / irq_v_o / irq_shv_o  out  SrcWidth / PrioWidth / ModeWidth / VsidWidth / 1 / 1  latched payload.
- irq_kill_req_o  out  1  kill to core.
- irq_kill_ack_i  in  1  core kill ack.
- irq_src_o  out  TgtWidth  index of the target currently offered.

Behaviour:
- Reset (rst_i high at a clk_i edge):
  - State is IDLE.
  - All outputs are 0, including irq_* payload, irq_src_o, tgt_ready_o and tgt_kill_ack_o.
- Rank: key = {rank, level}, compared unsigned.
  - rank 3 = mode 2'b11.
  - rank 2 = mode 2'b01 with v=0.
  - rank 1 = mode 2'b01 with v=1.
  - rank 0 = all other modes.
  - Equal keys: lowest target index wins.
- IDLE:
  - If any tgt_valid_i is set, latch the winner index and payload.
  - irq_valid_o=1 from the next cycle; go to OFFER.
  - Latency: valid at cycle t -> irq_valid_o at t+1.
- OFFER / KILL (irq_valid_o=1):
  - Payload and irq_src_o stay stable until irq_valid_o falls.
  - Ordered checks in these states, first match wins:
    - (a) irq_ready_i=1: tgt_ready_o[src]=1 in the same cycle (combinational); irq_valid_o=0 and irq_kill_req_o=0 next cycle; go to IDLE. No kill ack is given even if a kill was pending.
    - (b) tgt_valid_i[src]=0 (withdrawn): irq_valid_o=0 and irq_kill_req_o=0 next cycle; go to IDLE.
    - (c) In OFFER, tgt_kill_req_i[src]=1, or any other valid target has a strictly greater key than the latched key: irq_kill_req_o=1 next cycle; go to KILL. Record the cause: target-originated or preempt; both may be set.
    - (d) In KILL, irq_kill_req_o=1 and irq_kill_ack_i=1: irq_valid_o=0 and irq_kill_req_o=0 next cycle; go to IDLE. If target-originated, tgt_kill_ack_o[src]=1 in that cycle.
  - In KILL, a target kill request arriving after a preempt sets the target-originated cause.
  - A preempted target gets no kill ack, keeps valid, and is re-arbitrated.
- Throughput: one idle bubble. Handshake at t -> IDLE at t+1 -> next irq_valid_o at t+2.
- tgt_ready_o and tgt_kill_ack_o:
  - Asserted only for index src, never both in one cycle.
  - Never asserted in IDLE.
- No id mutation while offered: live changes on tgt_id_i of the selected target are ignored until re-offer.
- Reset mid-offer forces IDLE and drops irq_valid_o and irq_kill_req_o at that edge; no ready or ack pulse is issued.

Test Plan:
- Single request: tgt0 valid {mode=11, level=5, id=17}, ready at +3 -> irq_valid_o rises the cycle after tgt0 valid; irq_id_o=17, irq_level_o=5, irq_src_o=0; tgt_ready_o=2'b01 in the ready cycle; irq_valid_o=0 next cycle.
- Rank beats level: tgt0 {mode=01, v=1, level=255} and tgt1 {mode=01, v=0, level=1} valid together -> tgt1 offered, irq_src_o=1; after handshake tgt0 offered with a one-cycle bubble.
- Tie: both targets {mode=11, level=8} -> tgt0 offered first, then tgt1 after tgt0 completes.
- Preempt: tgt1 {mode=01, level=9} offered; tgt0 {mode=11, level=2} appears -> irq_kill_req_o=1 next cycle; on irq_kill_ack_i, irq_valid_o falls, tgt_kill_ack_o stays 0; tgt0 offered two cycles later.
- Target kill vs ready: tgt0 kill_req, then the core raises irq_ready_i and irq_kill_ack_i together -> tgt_ready_o[0]=1, tgt_kill_ack_o=0, irq_kill_req_o drops. Separate run with ack alone -> tgt_kill_ack_o[0]=1.
- Withdraw and reset: tgt0 valid drops while offered -> irq_valid_o=0 next cycle, no pulses. Separately, rst_i asserted during KILL -> all outputs 0 at that edge.
